// File: rtl/regfile_mp_pkg.sv
// Shared defaults for the multi-port register file: data width, register count,
// read-port count and the number of write ports.
package regfile_mp_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned REG_NUM_DEF = 32;
  localparam int unsigned NR_DEF      = 2;
  localparam int unsigned WR_PORTS    = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register and a registered
// population count that trails the pending vector by one cycle.
module regfile_scoreboard #(
  parameter int unsigned REG_NUM = 32,
  localparam int unsigned AW     = $clog2(REG_NUM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_NUM-1:0] set_vec,
  input  logic [REG_NUM-1:0] clr_vec,
  output logic [REG_NUM-1:0] pend,
  output logic [AW:0]        cnt
);

  logic [REG_NUM-1:0] pend_d;
  logic [AW:0]        cnt_d;

  // Set beats clear; x0 can never be pending.
  always_comb begin
    pend_d    = (pend & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      cnt_d = cnt_d + (AW+1)'(pend[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_d;
      cnt  <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned REG_NUM = REG_NUM_DEF,
  parameter int unsigned NR      = NR_DEF,
  localparam int unsigned AW     = $clog2(REG_NUM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NR*AW-1:0]         rd_addr_i,
  output logic [NR*XLEN-1:0]       rd_data_o,
  output logic [NR-1:0]            rd_busy_o,
  input  logic [WR_PORTS-1:0]      wr_en_i,
  input  logic [WR_PORTS*AW-1:0]   wr_addr_i,
  input  logic [WR_PORTS*XLEN-1:0] wr_data_i,
  input  logic                     sb_set_i,
  input  logic [AW-1:0]            sb_addr_i,
  output logic [AW:0]              pend_cnt_o
);

  logic [XLEN-1:0]    regs [REG_NUM];
  logic [AW-1:0]      wa   [WR_PORTS];
  logic [XLEN-1:0]    wd   [WR_PORTS];
  logic               wv   [WR_PORTS];
  logic [AW-1:0]      ra   [NR];
  logic [REG_NUM-1:0] set_vec;
  logic [REG_NUM-1:0] clr_vec;
  logic [REG_NUM-1:0] pend;

  // Unpack write ports; writes to x0 are dropped here once for all consumers.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      wa[p] = wr_addr_i[p*AW +: AW];
      wd[p] = wr_data_i[p*XLEN +: XLEN];
      wv[p] = wr_en_i[p] && (wa[p] != '0);
      if (wv[p]) clr_vec[wa[p]] = 1'b1;
    end
    if (sb_set_i && (sb_addr_i != '0)) set_vec[sb_addr_i] = 1'b1;
  end

  // Port 1 is applied last so it wins a same-register collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      for (int unsigned p = 0; p < WR_PORTS; p++) begin
        if (wv[p]) regs[wa[p]] <= wd[p];
      end
    end
  end

  regfile_scoreboard #(
    .REG_NUM (REG_NUM)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_vec (set_vec),
    .clr_vec (clr_vec),
    .pend    (pend),
    .cnt     (pend_cnt_o)
  );

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      ra[k] = rd_addr_i[k*AW +: AW];
      rd_data_o[k*XLEN +: XLEN] = (ra[k] == '0) ? '0 : regs[ra[k]];
      rd_busy_o[k]              = pend[ra[k]];
`ifdef REGFILE_BYPASS_EN
      // Forwarding is suppressed during reset since those writes are discarded.
      for (int unsigned p = 0; p < WR_PORTS; p++) begin
        if (rst_n && wv[p] && (wa[p] == ra[k])) begin
          rd_data_o[k*XLEN +: XLEN] = wd[p];
          rd_busy_o[k]              = sb_set_i && (sb_addr_i == ra[k]);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_NUM = 32;
  localparam int unsigned NR      = 2;
  localparam int unsigned AW      = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*AW-1:0]  rd_addr_i;
  logic [NR*XLEN-1:0] rd_data_o;
  logic [NR-1:0]     rd_busy_o;
  logic [1:0]        wr_en_i;
  logic [2*AW-1:0]   wr_addr_i;
  logic [2*XLEN-1:0] wr_data_i;
  logic              sb_set_i;
  logic [AW-1:0]     sb_addr_i;
  logic [AW:0]       pend_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN    (XLEN),
    .REG_NUM (REG_NUM),
    .NR      (NR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr_i  (rd_addr_i),
    .rd_data_o  (rd_data_o),
    .rd_busy_o  (rd_busy_o),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .wr_data_i  (wr_data_i),
    .sb_set_i   (sb_set_i),
    .sb_addr_i  (sb_addr_i),
    .pend_cnt_o (pend_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdat(input int k);
    return rd_data_o[k*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] busy(input int k);
    return 32'(rd_busy_o[k]);
  endfunction

  function automatic logic [31:0] cnt();
    return 32'(pend_cnt_o);
  endfunction

  task automatic idle();
    wr_en_i  = 2'b00;
    sb_set_i = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    rd_addr_i = '0;
    wr_addr_i = '0;
    wr_data_i = '0;
    sb_addr_i = '0;
    idle();
    @(negedge clk);
    @(negedge clk);
    check("cnt_in_reset", cnt(), 32'd0);
    rst_n = 1'b1;

    // Reset state across every address on both read ports.
    for (int a = 0; a < 32; a++) begin
      rd_addr_i = {AW'(31 - a), AW'(a)};
      #1;
      check("rst_data0", rdat(0), 32'd0);
      check("rst_data1", rdat(1), 32'd0);
      check("rst_busy0", busy(0), 32'd0);
      check("rst_busy1", busy(1), 32'd0);
    end
    check("rst_cnt", cnt(), 32'd0);

    // Same-register collision: port 1 wins.
    @(negedge clk);
    wr_en_i   = 2'b11;
    wr_addr_i = {AW'(5), AW'(5)};
    wr_data_i = {32'h12345678, 32'hAAAA5555};
    @(negedge clk);
    idle();
    rd_addr_i = {AW'(5), AW'(5)};
    #1;
    check("x5_port1_wins_r0", rdat(0), 32'h12345678);
    check("x5_port1_wins_r1", rdat(1), 32'h12345678);

    // Independent writes on both ports.
    wr_en_i   = 2'b11;
    wr_addr_i = {AW'(8), AW'(6)};
    wr_data_i = {32'h00002222, 32'h00001111};
    @(negedge clk);
    idle();
    rd_addr_i = {AW'(8), AW'(6)};
    #1;
    check("x6_wr0", rdat(0), 32'h00001111);
    check("x8_wr1", rdat(1), 32'h00002222);

    // x0 ignores writes and scoreboard sets.
    wr_en_i   = 2'b01;
    wr_addr_i = {AW'(0), AW'(0)};
    wr_data_i = {32'h0, 32'hFFFFFFFF};
    sb_set_i  = 1'b1;
    sb_addr_i = AW'(0);
    @(negedge clk);
    idle();
    rd_addr_i = {AW'(0), AW'(0)};
    #1;
    check("x0_data", rdat(0), 32'd0);
    check("x0_busy", busy(0), 32'd0);
    @(negedge clk);
    check("x0_cnt", cnt(), 32'd0);

    // Scoreboard set/clear sequence with one-cycle count latency.
    sb_set_i  = 1'b1;
    sb_addr_i = AW'(7);
    @(negedge clk);
    idle();
    rd_addr_i = {AW'(0), AW'(7)};
    #1;
    check("x7_busy", busy(0), 32'd1);
    check("cnt_lag", cnt(), 32'd0);
    sb_set_i  = 1'b1;
    sb_addr_i = AW'(9);
    @(negedge clk);
    idle();
    #1;
    check("cnt_1", cnt(), 32'd1);
    wr_en_i   = 2'b01;
    wr_addr_i = {AW'(0), AW'(7)};
    wr_data_i = {32'h0, 32'h00000077};
    @(negedge clk);
    idle();
    rd_addr_i = {AW'(9), AW'(7)};
    #1;
    check("x7_busy_clr", busy(0), 32'd0);
    check("x7_data", rdat(0), 32'h00000077);
    check("x9_busy", busy(1), 32'd1);
    check("cnt_2", cnt(), 32'd2);
    wr_en_i   = 2'b10;
    wr_addr_i = {AW'(9), AW'(0)};
    wr_data_i = {32'h00000099, 32'h0};
    sb_set_i  = 1'b1;
    sb_addr_i = AW'(9);
    @(negedge clk);
    idle();
    #1;
    check("cnt_after_clr", cnt(), 32'd1);
    check("x9_set_wins", busy(1), 32'd1);
    check("x9_data", rdat(1), 32'h00000099);
    @(negedge clk);
    check("cnt_hold", cnt(), 32'd1);

    // Same-cycle read of a register being written.
    wr_en_i   = 2'b01;
    wr_addr_i = {AW'(0), AW'(3)};
    wr_data_i = {32'h0, 32'h00000011};
    @(negedge clk);
    idle();
    wr_en_i   = 2'b11;
    wr_addr_i = {AW'(9), AW'(3)};
    wr_data_i = {32'h0000009A, 32'hDEADBEEF};
    rd_addr_i = {AW'(9), AW'(3)};
    #1;
    check("x3_same_cycle", rdat(0), BYP ? 32'hDEADBEEF : 32'h00000011);
    check("x9_same_cycle", rdat(1), BYP ? 32'h0000009A : 32'h00000099);
    check("x9_busy_fwd", busy(1), BYP ? 32'd0 : 32'd1);
    @(negedge clk);
    idle();
    #1;
    check("x3_stored", rdat(0), 32'hDEADBEEF);
    check("x9_stored", rdat(1), 32'h0000009A);
    check("x9_busy_done", busy(1), 32'd0);
    @(negedge clk);
    check("cnt_zero", cnt(), 32'd0);

    // Asynchronous reset mid-stream with a pending register and active write.
    sb_set_i  = 1'b1;
    sb_addr_i = AW'(4);
    @(negedge clk);
    idle();
    rd_addr_i = {AW'(5), AW'(4)};
    #1;
    check("x4_busy", busy(0), 32'd1);
    wr_en_i   = 2'b01;
    wr_addr_i = {AW'(0), AW'(4)};
    wr_data_i = {32'h0, 32'h00000044};
    sb_set_i  = 1'b1;
    sb_addr_i = AW'(10);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_x4_data", rdat(0), 32'd0);
    check("arst_x4_busy", busy(0), 32'd0);
    check("arst_cnt", cnt(), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    #1;
    check("post_rst_x4", rdat(0), 32'd0);
    check("post_rst_x5", rdat(1), 32'd0);
    @(negedge clk);
    check("post_rst_cnt", cnt(), 32'd0);
    wr_en_i   = 2'b01;
    wr_addr_i = {AW'(0), AW'(4)};
    wr_data_i = {32'h0, 32'h00001234};
    @(negedge clk);
    idle();
    #1;
    check("first_edge_write", rdat(0), 32'h00001234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width per register.
REQ-002 SHALL have parameter REG_NUM, default 32, register count (power of two, >=2); AW = log2(REG_NUM).
REQ-003 SHALL have parameter NR, default 2, number of read ports (1..4).
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rd_addr_i  input  NR*AW  read addresses, port k at bits [k*AW +: AW].
REQ-007 SHALL have port rd_data_o  output  NR*XLEN  read data, port k at bits [k*XLEN +: XLEN].
REQ-008 SHALL have port rd_busy_o  output  NR  per read port, addressed register has a pending write.
REQ-009 SHALL have port wr_en_i  input  2  write enables, ports 0 and 1.
REQ-010 SHALL have port wr_addr_i  input  2*AW  write addresses.
REQ-011 SHALL have port wr_data_i  input  2*XLEN  write data.
REQ-012 SHALL have port sb_set_i  input  1  mark register sb_addr_i as pending (instruction issued).
REQ-013 SHALL have port sb_addr_i  input  AW  scoreboard set address.
REQ-014 SHALL have port pend_cnt_o  output  AW+1  number of registers currently pending.

Function
REQ-015 SHALL return 0 on any read of x0 and SHALL ignore writes and scoreboard sets to x0.
REQ-016 SHALL update a register on the rising clk edge when the corresponding wr_en_i bit is set.
REQ-017 SHALL let write port 1 win when both write ports target the same register in the same cycle.
REQ-018 SHALL clear a register's pending bit on the edge that writes it through either port.
REQ-019 SHALL set the pending bit on the edge where sb_set_i=1; set SHALL win over a same-cycle clear of the same register.
REQ-020 SHALL drive rd_busy_o[k] combinationally from the pending bit of rd_addr_i[k], subject to REQ-025.
REQ-021 SHALL update pend_cnt_o registered, exactly one cycle after the set/clear edge, with no overflow (max REG_NUM-1).
REQ-022 SHALL give reads zero-cycle combinational latency; without bypass the read returns the pre-edge register value.

Reset
REQ-023 SHALL clear all registers, all pending bits and pend_cnt_o to 0 while rst_n=0, irrespective of clk.
REQ-024 SHALL discard any write or set presented in the cycle in which reset is asserted; the first edge after deassertion SHALL act normally.

Configuration
REQ-025 With REGFILE_BYPASS_EN defined: a read whose address matches an enabled, non-x0 write SHALL return that write data (port 1 over port 0), and rd_busy_o SHALL be 0 for it unless sb_set_i targets the same address.
REQ-026 Without REGFILE_BYPASS_EN: no forwarding, read returns stored value, rd_busy_o reflects the stored pending bit only.

Structure
REQ-027 SHALL take XLEN/REG_NUM defaults and the read-port packing macros from the shared buceros header.
REQ-028 SHALL place the pending bits and the counter in sub-module regfile_scoreboard (inputs: set, clear vector; outputs: pending vector, count).

Verification
REQ-029 Reset, then read all addresses -> all data 0, rd_busy_o 0, pend_cnt_o 0.
REQ-030 wr0 x5=0xAAAA5555 and wr1 x5=0x12345678 in the same cycle -> x5 reads 0x12345678 next cycle.
REQ-031 Write x0=0xFFFFFFFF, sb_set x0 -> x0 reads 0, pend_cnt_o stays 0.
REQ-032 sb_set x7, then x9 -> pend_cnt_o 1, then 2; write x7 -> rd_busy for x7 = 0, count 1 next cycle; same-cycle set+write x9 -> x9 stays busy.
REQ-033 Bypass build: read x3 while writing x3=0xDEADBEEF -> rd_data 0xDEADBEEF same cycle; non-bypass build -> old value.
REQ-034 Assert rst_n mid-stream with x4 pending and wr_en active -> x4=0, busy 0, count 0 immediately.
